// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: bus widths, state codes,
// the captured-request record and the address range check.
package mem_responder_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int ADDRESS_WIDTH  = 26;
   localparam int WAIT_CNT_WIDTH = 4;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'b00,
      MEM_WAIT = 2'b01,
      MEM_RESP = 2'b10
   } mem_state_t;

   typedef struct packed {
      logic                     rd;
      logic                     wr;
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    data;
   } mem_req_t;

   localparam mem_req_t REQ_CLEAR = '{rd: 1'b0, wr: 1'b0, addr: 26'd0, data: 32'd0};

   // Any set address bit at or above depth_log2 points outside the array.
   function automatic logic addr_out_of_range(input logic [ADDRESS_WIDTH-1:0] addr,
                                              input int depth_log2);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < ADDRESS_WIDTH; i++) begin
         hit = hit | (addr[i] & (i >= depth_log2));
      end
      return hit;
   endfunction

endpackage

// File: rtl/mem_responder_storage.sv
// Word-addressed storage array: synchronous write, combinational read.
// Contents are intentionally not cleared by reset.
module mem_responder_storage
   import mem_responder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_r [2**DEPTH_LOG2];

   // Commit one word per enabled clock edge.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one READ/WRITE request, waits WAIT_STATES
// cycles, performs the access and reports completion with READY (and ERR).
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     read,
   input  logic                     write,
   input  logic [ADDRESS_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0]    data_in,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     ready,
   output logic                     err
);

   localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   mem_state_t                state_r, state_s;
   logic [WAIT_CNT_WIDTH-1:0] cnt_r, cnt_s;
   mem_req_t                  req_r, cur_s;
   logic                      accept_s;
   logic                      enter_resp_s;
   logic                      err_s;
   logic                      wr_en_s;
   logic [DATA_WIDTH-1:0]     rd_data_s;
   logic [DATA_WIDTH-1:0]     data_out_r;
   logic                      ready_r;
   logic                      err_r;

   assign accept_s = (state_r == MEM_IDLE) && (read || write);

   // With zero wait states the access happens on the accept edge itself, so
   // the live inputs stand in for the not-yet-captured request while idle.
   always_comb begin
      cur_s = req_r;
      if (state_r == MEM_IDLE) begin
         cur_s.rd   = read;
         cur_s.wr   = write;
         cur_s.addr = addr;
         cur_s.data = data_in;
      end else begin
         cur_s = req_r;
      end
   end

   assign err_s = (cur_s.rd && cur_s.wr) || addr_out_of_range(cur_s.addr, DEPTH_LOG2);

   // Next-state and wait-counter logic.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      enter_resp_s = 1'b0;
      case (state_r)
         MEM_IDLE: begin
            if (accept_s) begin
               if (WAIT_STATES > 0) begin
                  state_s = MEM_WAIT;
                  cnt_s   = WAIT_LOAD;
               end else begin
                  state_s      = MEM_RESP;
                  enter_resp_s = 1'b1;
               end
            end else begin
               state_s = MEM_IDLE;
            end
         end
         MEM_WAIT: begin
            if (cnt_r == 4'd0) begin
               state_s      = MEM_RESP;
               enter_resp_s = 1'b1;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         MEM_RESP: begin
            state_s = MEM_IDLE;
         end
         default: begin
            state_s = MEM_IDLE;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // State register and wait counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= MEM_IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Request capture on accept; later input changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_r <= REQ_CLEAR;
      end else if (accept_s) begin
         req_r <= cur_s;
      end else begin
         req_r <= req_r;
      end
   end

   // rst_n gate keeps a request presented during reset from reaching storage.
   assign wr_en_s = enter_resp_s && cur_s.wr && !err_s && rst_n;

   mem_responder_storage #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_storage (
      .clk     (clk),
      .wr_en   (wr_en_s),
      .addr    (cur_s.addr[DEPTH_LOG2-1:0]),
      .wr_data (cur_s.data),
      .rd_data (rd_data_s)
   );

   // Read data is loaded on the edge entering RESP and held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_r <= 32'd0;
      end else if (enter_resp_s && cur_s.rd) begin
         data_out_r <= err_s ? 32'd0 : rd_data_s;
      end else begin
         data_out_r <= data_out_r;
      end
   end

   // Completion pulses, registered out of the RESP cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         ready_r <= (state_r == MEM_RESP);
         err_r   <= (state_r == MEM_RESP) && err_s;
      end
   end

   assign data_out = data_out_r;
   assign ready    = ready_r;
   assign err      = err_r;

endmodule
